// File: rtl/grf_wb_arb_if.sv
// Register-file write arbitration bus: pipeline writeback, multi-cycle unit results,
// the shared register-file write port and the pending-write lookup.
interface grf_wb_arb_if;
  logic        wb_we;
  logic [4:0]  wb_a3;
  logic [31:0] wb_wd;
  logic [31:0] wb_pc;
  logic        wb_ack;

  logic        md_valid;
  logic [4:0]  md_a3;
  logic [31:0] md_wd;
  logic [31:0] md_pc;
  logic        md_ready;

  logic        grf_we;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd;
  logic [31:0] grf_pc;

  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        fwd1_hit;
  logic [31:0] fwd1_data;
  logic        fwd2_hit;
  logic [31:0] fwd2_data;

  // Requesters and the lookup consumer
  modport master (
    output wb_we, wb_a3, wb_wd, wb_pc, md_valid, md_a3, md_wd, md_pc, rs1, rs2,
    input  wb_ack, md_ready, grf_we, grf_a3, grf_wd, grf_pc,
    input  fwd1_hit, fwd1_data, fwd2_hit, fwd2_data
  );

  // Arbiter
  modport slave (
    input  wb_we, wb_a3, wb_wd, wb_pc, md_valid, md_a3, md_wd, md_pc, rs1, rs2,
    output wb_ack, md_ready, grf_we, grf_a3, grf_wd, grf_pc,
    output fwd1_hit, fwd1_data, fwd2_hit, fwd2_data
  );
endinterface

// File: rtl/grf_wb_arb.sv
// Single register-file write port shared by pipeline writeback and a 2-deep MDU result FIFO.
// Define GRF_ARB_FWD_EN to enable lookup of pending FIFO writes for rs1/rs2.
module grf_wb_arb #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         reset,
  grf_wb_arb_if.slave  bus
);

  typedef struct packed {
    logic        valid;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
  } entry_t;

  typedef enum logic [1:0] {GntIdle, GntWb, GntHead} gnt_e;

  localparam logic [2:0] StarveMax = 3'(STARVE_LIMIT);

  entry_t     ent_q [2];
  entry_t     ent_d [2];
  entry_t     new_ent;
  logic [2:0] starve_q, starve_d;

  gnt_e gnt;
  logic wb_active, head_valid, forced, md_ready;
  logic wb_gnt, head_gnt, keep0, keep1, enq;

  // Slot 0 is always the head; kept entries are compacted toward it every cycle, so an
  // entry invalidated by a newer WB write never occupies the head.
  always_ff @(posedge clk) begin
    if (reset) begin
      ent_q[0] <= '0;
      ent_q[1] <= '0;
      starve_q <= '0;
    end else begin
      ent_q[0] <= ent_d[0];
      ent_q[1] <= ent_d[1];
      starve_q <= starve_d;
    end
  end

  always_comb begin
    wb_active  = bus.wb_we && (bus.wb_a3 != 5'd0);
    head_valid = ent_q[0].valid;
    forced     = head_valid && (starve_q == StarveMax);
    if (forced)          gnt = GntHead;
    else if (wb_active)  gnt = GntWb;
    else if (head_valid) gnt = GntHead;
    else                 gnt = GntIdle;
    wb_gnt   = (gnt == GntWb);
    head_gnt = (gnt == GntHead);
    // A slot frees up in the same cycle the head leaves
    md_ready = !ent_q[1].valid || head_gnt;
  end

  always_comb begin
    keep0 = ent_q[0].valid && !head_gnt && !(wb_gnt && (ent_q[0].a3 == bus.wb_a3));
    keep1 = ent_q[1].valid && !(wb_gnt && (ent_q[1].a3 == bus.wb_a3));
    // A result racing a WB to the same register is the older write and is dropped
    enq   = bus.md_valid && md_ready && (bus.md_a3 != 5'd0)
            && !(wb_gnt && (bus.md_a3 == bus.wb_a3));
    new_ent = {1'b1, bus.md_a3, bus.md_wd, bus.md_pc};

    ent_d[0] = '0;
    ent_d[1] = '0;
    if (keep0) begin
      ent_d[0] = ent_q[0];
      if (keep1)    ent_d[1] = ent_q[1];
      else if (enq) ent_d[1] = new_ent;
    end else if (keep1) begin
      ent_d[0] = ent_q[1];
      if (enq) ent_d[1] = new_ent;
    end else if (enq) begin
      ent_d[0] = new_ent;
    end

    if (head_gnt)                  starve_d = '0;
    else if (wb_gnt && head_valid) starve_d = 3'(starve_q + 3'd1);
    else                           starve_d = starve_q;
    if (!ent_d[0].valid) starve_d = '0;
  end

  always_comb begin
    bus.wb_ack   = !(forced && wb_active);
    bus.md_ready = md_ready;
    bus.grf_we   = 1'b0;
    bus.grf_a3   = '0;
    bus.grf_wd   = '0;
    bus.grf_pc   = '0;
    unique case (gnt)
      GntWb: begin
        bus.grf_we = 1'b1;
        bus.grf_a3 = bus.wb_a3;
        bus.grf_wd = bus.wb_wd;
        bus.grf_pc = bus.wb_pc;
      end
      GntHead: begin
        bus.grf_we = 1'b1;
        bus.grf_a3 = ent_q[0].a3;
        bus.grf_wd = ent_q[0].wd;
        bus.grf_pc = ent_q[0].pc;
      end
      default: ;
    endcase
  end

`ifdef GRF_ARB_FWD_EN
  // Youngest matching entry wins, so check slot 1 before slot 0
  function automatic logic [32:0] lookup(input logic [4:0] rs, input entry_t e0, input entry_t e1);
    if (rs == 5'd0)                   return '0;
    if (e1.valid && (e1.a3 == rs))    return {1'b1, e1.wd};
    if (e0.valid && (e0.a3 == rs))    return {1'b1, e0.wd};
    return '0;
  endfunction

  always_comb begin
    {bus.fwd1_hit, bus.fwd1_data} = lookup(bus.rs1, ent_q[0], ent_q[1]);
    {bus.fwd2_hit, bus.fwd2_data} = lookup(bus.rs2, ent_q[0], ent_q[1]);
  end
`else
  logic unused_rs;
  assign unused_rs = ^{bus.rs1, bus.rs2};

  always_comb begin
    bus.fwd1_hit  = 1'b0;
    bus.fwd1_data = '0;
    bus.fwd2_hit  = 1'b0;
    bus.fwd2_data = '0;
  end
`endif

endmodule

// File: tb/tb_grf_wb_arb.sv
// Directed and randomized bench for grf_wb_arb against a queue-based reference model.
module tb_grf_wb_arb;
  localparam int Limit = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  grf_wb_arb_if bus ();

  grf_wb_arb #(.STARVE_LIMIT(Limit)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
  } ent_t;

  ent_t q[$];
  int   starve;
  int   checks = 0;
  int   failures = 0;

  logic        exp_we, exp_ack, exp_ready, exp_f1h, exp_f2h;
  logic [4:0]  exp_a3;
  logic [31:0] exp_wd, exp_pc, exp_f1d, exp_f2d;
  logic        m_gnt_wb, m_gnt_head;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fwd_lookup(input logic [4:0] rs, output logic hit, output logic [31:0] data);
    hit  = 1'b0;
    data = '0;
`ifdef GRF_ARB_FWD_EN
    if (rs != 5'd0) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].a3 == rs) begin
          hit  = 1'b1;
          data = q[i].wd;
          break;
        end
      end
    end
`endif
  endtask

  task automatic model_eval();
    logic wb_act, forced;
    wb_act     = bus.wb_we && (bus.wb_a3 != 5'd0);
    forced     = (q.size() > 0) && (starve == Limit);
    m_gnt_head = forced || (!wb_act && q.size() > 0);
    m_gnt_wb   = !forced && wb_act;
    exp_we = m_gnt_head || m_gnt_wb;
    exp_a3 = '0;
    exp_wd = '0;
    exp_pc = '0;
    if (m_gnt_head) begin
      exp_a3 = q[0].a3;
      exp_wd = q[0].wd;
      exp_pc = q[0].pc;
    end else if (m_gnt_wb) begin
      exp_a3 = bus.wb_a3;
      exp_wd = bus.wb_wd;
      exp_pc = bus.wb_pc;
    end
    exp_ack   = !(forced && wb_act);
    exp_ready = (q.size() < 2) || m_gnt_head;
    fwd_lookup(bus.rs1, exp_f1h, exp_f1d);
    fwd_lookup(bus.rs2, exp_f2h, exp_f2d);
  endtask

  task automatic model_update();
    bit   was_nonempty;
    ent_t e;
    was_nonempty = (q.size() > 0);
    if (m_gnt_head) void'(q.pop_front());
    if (m_gnt_wb) begin
      for (int i = q.size() - 1; i >= 0; i--)
        if (q[i].a3 == bus.wb_a3) q.delete(i);
    end
    if (bus.md_valid && exp_ready && bus.md_a3 != 5'd0
        && !(m_gnt_wb && bus.md_a3 == bus.wb_a3)) begin
      e.a3 = bus.md_a3;
      e.wd = bus.md_wd;
      e.pc = bus.md_pc;
      q.push_back(e);
    end
    if (m_gnt_head)                    starve = 0;
    else if (m_gnt_wb && was_nonempty) starve++;
    if (q.size() == 0) starve = 0;
  endtask

  // Check every output against the model at the falling edge
  task automatic sample();
    @(negedge clk);
    model_eval();
    if (!reset) begin
      chk("grf_we", 32'(bus.grf_we), 32'(exp_we));
      chk("grf_a3", 32'(bus.grf_a3), 32'(exp_a3));
      chk("grf_wd", bus.grf_wd, exp_wd);
      chk("grf_pc", bus.grf_pc, exp_pc);
      chk("wb_ack", 32'(bus.wb_ack), 32'(exp_ack));
      chk("md_ready", 32'(bus.md_ready), 32'(exp_ready));
      chk("fwd1_hit", 32'(bus.fwd1_hit), 32'(exp_f1h));
      chk("fwd1_data", bus.fwd1_data, exp_f1d);
      chk("fwd2_hit", 32'(bus.fwd2_hit), 32'(exp_f2h));
      chk("fwd2_data", bus.fwd2_data, exp_f2d);
    end
  endtask

  task automatic advance();
    @(posedge clk);
    if (reset) begin
      q.delete();
      starve = 0;
    end else begin
      model_update();
    end
    #1;
  endtask

  task automatic set_wb(input logic we, input logic [4:0] a3, input logic [31:0] wd);
    bus.wb_we = we;
    bus.wb_a3 = a3;
    bus.wb_wd = wd;
    bus.wb_pc = 32'h1000 + 32'(a3);
  endtask

  task automatic set_md(input logic v, input logic [4:0] a3, input logic [31:0] wd);
    bus.md_valid = v;
    bus.md_a3    = a3;
    bus.md_wd    = wd;
    bus.md_pc    = 32'h2000 + 32'(a3);
  endtask

  initial begin
    bit stall;
    q.delete();
    starve = 0;
    reset  = 1'b1;
    set_wb(1'b0, 5'd0, 32'h0);
    set_md(1'b0, 5'd0, 32'h0);
    bus.rs1 = '0;
    bus.rs2 = '0;
    #1;
    sample(); advance();
    sample(); advance();
    reset = 1'b0;

    // Reset state
    sample();
    chk("rst_md_ready", 32'(bus.md_ready), 32'd1);
    chk("rst_wb_ack", 32'(bus.wb_ack), 32'd1);
    chk("rst_grf_we", 32'(bus.grf_we), 32'd0);
    chk("rst_fwd1_hit", 32'(bus.fwd1_hit), 32'd0);
    chk("rst_fwd2_hit", 32'(bus.fwd2_hit), 32'd0);
    advance();

    // WB-only writes
    set_wb(1'b1, 5'd5, 32'h11);
    repeat (3) begin
      sample();
      chk("wbonly_we", 32'(bus.grf_we), 32'd1);
      chk("wbonly_a3", 32'(bus.grf_a3), 32'd5);
      chk("wbonly_ack", 32'(bus.wb_ack), 32'd1);
      advance();
    end
    set_wb(1'b0, 5'd0, 32'h0);

    // MDU result with WB idle appears the cycle after enqueue
    set_md(1'b1, 5'd7, 32'hAA);
    sample();
    chk("md_enq_we", 32'(bus.grf_we), 32'd0);
    chk("md_enq_ready", 32'(bus.md_ready), 32'd1);
    advance();
    set_md(1'b0, 5'd0, 32'h0);
    sample();
    chk("md_wr_we", 32'(bus.grf_we), 32'd1);
    chk("md_wr_a3", 32'(bus.grf_a3), 32'd7);
    chk("md_wr_wd", bus.grf_wd, 32'hAA);
    chk("md_wr_ready", 32'(bus.md_ready), 32'd1);
    advance();
    sample(); chk("md_idle_we", 32'(bus.grf_we), 32'd0); advance();

    // Starvation: WB wins Limit cycles, then the head is forced through
    set_wb(1'b1, 5'd5, 32'h22);
    set_md(1'b1, 5'd7, 32'h77);
    sample(); advance();
    set_md(1'b0, 5'd0, 32'h0);
    repeat (Limit) begin
      sample();
      chk("starve_wb_a3", 32'(bus.grf_a3), 32'd5);
      chk("starve_wb_ack", 32'(bus.wb_ack), 32'd1);
      advance();
    end
    sample();
    chk("forced_a3", 32'(bus.grf_a3), 32'd7);
    chk("forced_wd", bus.grf_wd, 32'h77);
    chk("forced_ack", 32'(bus.wb_ack), 32'd0);
    advance();
    sample();
    chk("after_forced_a3", 32'(bus.grf_a3), 32'd5);
    chk("after_forced_ack", 32'(bus.wb_ack), 32'd1);
    advance();

    // Newer WB write kills the queued stale MDU write
    set_md(1'b1, 5'd9, 32'h1);
    sample(); advance();
    set_md(1'b0, 5'd0, 32'h0);
    set_wb(1'b1, 5'd9, 32'h2);
    sample();
    chk("kill_wb_a3", 32'(bus.grf_a3), 32'd9);
    chk("kill_wb_wd", bus.grf_wd, 32'h2);
    advance();
    set_wb(1'b0, 5'd0, 32'h0);
    repeat (3) begin
      sample(); chk("kill_no_write", 32'(bus.grf_we), 32'd0); advance();
    end

    // FIFO fills while WB is busy, then reset drops everything
    set_wb(1'b1, 5'd5, 32'h33);
    set_md(1'b1, 5'd10, 32'hA0);
    sample(); advance();
    set_md(1'b1, 5'd11, 32'hB0);
    sample(); chk("fill2_ready", 32'(bus.md_ready), 32'd1); advance();
    set_md(1'b1, 5'd12, 32'hC0);
    repeat (2) begin
      sample(); chk("full_ready", 32'(bus.md_ready), 32'd0); advance();
    end
    reset = 1'b1;
    sample(); advance();
    reset = 1'b0;
    set_wb(1'b0, 5'd0, 32'h0);
    set_md(1'b0, 5'd0, 32'h0);
    repeat (2) begin
      sample();
      chk("post_rst_we", 32'(bus.grf_we), 32'd0);
      chk("post_rst_ready", 32'(bus.md_ready), 32'd1);
      advance();
    end

    // Pending-write lookup
    set_wb(1'b1, 5'd5, 32'h44);
    set_md(1'b1, 5'd3, 32'h5);
    sample(); advance();
    set_md(1'b1, 5'd3, 32'h6);
    sample(); advance();
    set_md(1'b0, 5'd0, 32'h0);
    bus.rs1 = 5'd3;
    bus.rs2 = 5'd0;
    sample();
`ifdef GRF_ARB_FWD_EN
    chk("fwd1_hit_young", 32'(bus.fwd1_hit), 32'd1);
    chk("fwd1_data_young", bus.fwd1_data, 32'h6);
`else
    chk("fwd1_hit_tied", 32'(bus.fwd1_hit), 32'd0);
    chk("fwd1_data_tied", bus.fwd1_data, 32'h0);
`endif
    chk("fwd2_hit_rs0", 32'(bus.fwd2_hit), 32'd0);
    advance();
    set_wb(1'b0, 5'd0, 32'h0);
    repeat (3) begin sample(); advance(); end

    // Random traffic; WB holds its request while not acknowledged
    stall = 1'b0;
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 79) == 0);
      if (!stall)
        set_wb($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom);
      set_md($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)), $urandom);
      bus.rs1 = 5'($urandom_range(0, 7));
      bus.rs2 = 5'($urandom_range(0, 7));
      sample();
      stall = !reset && !exp_ack;
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/grf_wb_arb.md
GRF_WB_ARB -- requirements
Module: grf_wb_arb

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, meaning the cycles a waiting FIFO head may lose to WB before it forcibly wins (legal 1..7).
REQ-002 SHALL have ports clk  in  1  clock; reset  in  1  reset, synchronous, active-high.
REQ-003 SHALL have wb_we in 1, wb_a3 in 5, wb_wd in 32, wb_pc in 32 as the pipeline writeback request; wb_ack out 1 means WB owns the port this cycle.
REQ-004 SHALL have md_valid in 1, md_a3 in 5, md_wd in 32, md_pc in 32 as the multi-cycle unit result; md_ready out 1 means accepted.
REQ-005 SHALL have grf_we out 1, grf_a3 out 5, grf_wd out 32, grf_pc out 32 as the single register-file write port.
REQ-006 SHALL have rs1 in 5, rs2 in 5; fwd1_hit out 1, fwd1_data out 32, fwd2_hit out 1, fwd2_data out 32 as pending-write lookup.

Function
REQ-007 SHALL hold MDU results in a 2-entry in-order FIFO (entry: valid, a3, wd, pc); md_ready = FIFO not full, combinational.
REQ-008 SHALL enqueue on md_valid && md_ready when md_a3 != 0; md_a3 == 0 is accepted and discarded.
REQ-009 SHALL treat a WB request as active only when wb_we && wb_a3 != 0; an inactive WB never takes the port, and wb_ack = 1 while inactive.
REQ-010 SHALL grant per cycle, combinationally: forced head (starve_cnt == STARVE_LIMIT and FIFO non-empty) > active WB > FIFO head > idle.
REQ-011 SHALL drive grf_* from the granted source; grf_we = 0 and grf_a3/wd/pc = 0 when idle.
REQ-012 SHALL drop wb_ack only during a forced-head cycle with active WB; WB holds its request unchanged and is granted next cycle.
REQ-013 SHALL dequeue the head in the cycle it is granted; enqueue and dequeue in the same cycle are both honoured, including when full.
REQ-014 SHALL keep 3-bit starve_cnt: +1 each cycle the FIFO is non-empty and WB wins; cleared when the head is granted or the FIFO empties.
REQ-015 SHALL, when WB is granted to register X, invalidate every FIFO entry with a3 == X (stale older write); invalidated entries are dequeued without using the port.
REQ-016 SHALL treat an MDU result arriving in the same cycle as a granted WB to the same register as older and discard it (md_ready still 1).
REQ-017 SHALL kill invalid head entries in the cycle they reach the head, so a valid entry behind is granted that same cycle.
REQ-018 SHALL add exactly zero cycles latency from grant to grf_*: all port outputs are combinational from the grant.

Reset
REQ-019 SHALL on reset empty the FIFO, clear all entry valid bits and starve_cnt; after reset md_ready = 1, wb_ack = 1, grf_we = 0, fwd*_hit = 0.
REQ-020 SHALL discard any queued MDU results on reset mid-operation; no grf_we for them after reset.

Configuration
REQ-021 SHALL, with GRF_ARB_FWD_EN defined, set fwdN_hit = 1 and fwdN_data = wd of the youngest valid FIFO entry with a3 == rsN (rsN != 0); otherwise hit 0, data 0.
REQ-022 SHALL, without GRF_ARB_FWD_EN, tie fwd1_hit, fwd2_hit, fwd1_data, fwd2_data to 0 and contain no lookup logic.

Verification
REQ-023 SHALL cover: WB-only writes $5<=0x11 each cycle -> grf_we=1, grf_a3=5, wb_ack=1, FIFO untouched.
REQ-024 SHALL cover: md_valid $7<=0xAA with WB idle -> grf_we=1, a3=7, wd=0xAA in the cycle after enqueue; md_ready stays 1.
REQ-025 SHALL cover: FIFO holds $7, WB active continuously, STARVE_LIMIT=4 -> WB wins 4 cycles, 5th cycle grf_a3=7, wb_ack=0; WB written the cycle after.
REQ-026 SHALL cover: FIFO holds $9<=0x1, WB writes $9<=0x2 -> FIFO entry killed; $9 never rewritten with 0x1.
REQ-027 SHALL cover: two MDU results with WB busy -> md_ready=0; third md_valid held until a dequeue; reset asserted then -> FIFO empty, no pending grf_we.
REQ-028 SHALL cover (GRF_ARB_FWD_EN): FIFO $3<=0x5 then $3<=0x6, rs1=3 -> fwd1_hit=1, fwd1_data=0x6; rs2=0 -> fwd2_hit=0.
